// File: rtl/icevga_pattern.sv
// icevga_pattern: pixel-colour stage producing four test patterns for the 800x600 SVGA DAC path.
module icevga_pattern #(
    parameter int H_VISIBLE = 800,
    parameter int V_VISIBLE = 600,
    parameter int BOX_SIZE  = 64
) (
    input  logic       pllclk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic       h_visible,
    input  logic       v_visible,
    input  logic       frame_start,
    input  logic [1:0] pattern_sel,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue
);
    localparam logic [9:0]  X_LAST = 10'(H_VISIBLE - 1);
    localparam logic [9:0]  Y_LAST = 10'(V_VISIBLE - 1);
    localparam logic [9:0]  LX     = 10'(H_VISIBLE - BOX_SIZE);
    localparam logic [9:0]  LY     = 10'(V_VISIBLE - BOX_SIZE);
    localparam logic [10:0] BOX_W  = 11'(BOX_SIZE);
    localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                         12'hF0F, 12'hF00, 12'h00F, 12'h000};
    logic [9:0]  x, y, box_x, box_y;
    logic        dx, dy;
    logic [1:0]  sel_q;
    logic [2:0]  bar;
    logic        in_box;
    logic [11:0] rgb;
    always_comb begin
        bar = x < 10'd100 ? 3'd0 : x < 10'd200 ? 3'd1 : x < 10'd300 ? 3'd2 :
              x < 10'd400 ? 3'd3 : x < 10'd500 ? 3'd4 : x < 10'd600 ? 3'd5 :
              x < 10'd700 ? 3'd6 : 3'd7;
        in_box = x >= box_x && {1'b0, x} < {1'b0, box_x} + BOX_W &&
                 y >= box_y && {1'b0, y} < {1'b0, box_y} + BOX_W;
        rgb = !(h_visible && v_visible) ? 12'h000 :
              sel_q == 2'd0 ? 12'h71E :
              sel_q == 2'd1 ? BARS[bar] :
              sel_q == 2'd2 ? {12{x[5] ^ y[5]}} :
              in_box ? 12'hF0F : 12'h002;
    end
    always_ff @(posedge pllclk) begin
        if (reset) begin
            {red, green, blue} <= 12'h000;
            x     <= '0;
            y     <= '0;
            sel_q <= '0;
            box_x <= '0;
            box_y <= '0;
            dx    <= 1'b1;
            dy    <= 1'b1;
        end else if (pix_en) begin
            {red, green, blue} <= rgb;
            x <= !h_visible ? 10'd0 : x == X_LAST ? 10'd0 : x + 10'd1;
            if (frame_start)
                y <= '0;
            else if (h_visible && v_visible && x == X_LAST)
                y <= y == Y_LAST ? 10'd0 : y + 10'd1;
            if (frame_start) begin
                sel_q <= pattern_sel;
                // Bounce off each wall by stepping one pixel back inside, so the edge value shows once
                box_x <= dx ? (box_x == LX ? LX - 10'd1 : box_x + 10'd1) : (box_x == 10'd0 ? 10'd1 : box_x - 10'd1);
                box_y <= dy ? (box_y == LY ? LY - 10'd1 : box_y + 10'd1) : (box_y == 10'd0 ? 10'd1 : box_y - 10'd1);
                dx    <= dx ? box_x != LX : box_x == 10'd0;
                dy    <= dy ? box_y != LY : box_y == 10'd0;
            end
        end
    end
endmodule

// File: tb/tb_icevga_pattern.sv
// tb_icevga_pattern: directed bench for icevga_pattern with a small reference model of the pattern stage.
module tb_icevga_pattern;
    logic       pllclk = 1'b0;
    logic       reset = 1'b0;
    logic       pix_en = 1'b0;
    logic       h_visible = 1'b0;
    logic       v_visible = 1'b0;
    logic       frame_start = 1'b0;
    logic [1:0] pattern_sel = 2'd0;
    logic [3:0] red, green, blue;
    int n_chk = 0, n_pass = 0, per = 1;
    int mx, my, bx, by;
    bit mdx, mdy;
    logic [1:0] msel;
    logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                              12'hF0F, 12'hF00, 12'h00F, 12'h000};
    icevga_pattern dut (
        .pllclk(pllclk), .reset(reset), .pix_en(pix_en), .h_visible(h_visible),
        .v_visible(v_visible), .frame_start(frame_start), .pattern_sel(pattern_sel),
        .red(red), .green(green), .blue(blue)
    );
    always #2 pllclk = ~pllclk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    function automatic logic [11:0] model_rgb(input bit h, input bit v);
        if (!(h && v)) return 12'h000;
        case (msel)
            2'd0: return 12'h71E;
            2'd1: return bars[mx / 100];
            2'd2: return (((mx >> 5) ^ (my >> 5)) & 1) != 0 ? 12'hFFF : 12'h000;
            default: return (mx >= bx && mx < bx + 64 && my >= by && my < by + 64) ? 12'hF0F : 12'h002;
        endcase
    endfunction
    task automatic model_reset();
        mx = 0; my = 0; bx = 0; by = 0; mdx = 1; mdy = 1; msel = 2'd0;
    endtask
    task automatic do_reset(input int n);
        reset = 1'b1; pix_en = 1'b1; h_visible = 1'b1; v_visible = 1'b1; frame_start = 1'b0;
        repeat (n) begin
            @(posedge pllclk); #1;
            check("reset rgb", {red, green, blue}, 12'h000);
        end
        reset = 1'b0; pix_en = 1'b0;
        model_reset();
    endtask
    task automatic px(input bit h, input bit v, input bit fs);
        logic [11:0] exp;
        string tag;
        exp = model_rgb(h, v);
        tag = $sformatf("pix x%0d y%0d sel%0d", mx, my, msel);
        h_visible = h; v_visible = v; frame_start = fs; pix_en = 1'b1;
        @(posedge pllclk); #1;
        pix_en = 1'b0; frame_start = 1'b0;
        check(tag, {red, green, blue}, exp);
        if (fs) begin
            msel = pattern_sel;
            if (mdx) begin if (bx == 736) begin mdx = 0; bx = 735; end else bx++; end
            else if (bx == 0) begin mdx = 1; bx = 1; end else bx--;
            if (mdy) begin if (by == 536) begin mdy = 0; by = 535; end else by++; end
            else if (by == 0) begin mdy = 1; by = 1; end else by--;
        end
        if (fs) my = 0;
        else if (h && v && mx == 799) my = my == 599 ? 0 : my + 1;
        mx = !h ? 0 : mx == 799 ? 0 : mx + 1;
        repeat (per - 1) begin
            @(posedge pllclk); #1;
            check("hold between strobes", {red, green, blue}, exp);
        end
    endtask
    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
    initial begin
        model_reset();
        do_reset(2);
        // reset during active video
        per = 6;
        px(0, 0, 1);
        px(1, 1, 0);
        check("solid before reset", {red, green, blue}, 12'h71E);
        do_reset(3);
        px(0, 0, 1);
        px(1, 1, 0);
        check("solid after reset", {red, green, blue}, 12'h71E);
        // solid with horizontal and vertical blanking
        px(0, 0, 1);
        for (int c = 0; c < 8; c++) px(1, 1, 0);
        per = 2;
        for (int l = 0; l < 3; l++)
            for (int c = 0; c < 1056; c++) px(c < 800, 1, 0);
        for (int c = 0; c < 1056; c++) px(c < 800, 0, 0);
        px(0, 0, 0);
        check("blank rgb", {red, green, blue}, 12'h000);
        // colour bars on line 0
        per = 1;
        pattern_sel = 2'd1;
        px(0, 0, 1);
        for (int c = 0; c < 800; c++) begin
            px(1, 1, 0);
            if (c == 0)   check("bar x0",   {red, green, blue}, 12'hFFF);
            if (c == 99)  check("bar x99",  {red, green, blue}, 12'hFFF);
            if (c == 100) check("bar x100", {red, green, blue}, 12'hFF0);
            if (c == 699) check("bar x699", {red, green, blue}, 12'h00F);
            if (c == 700) check("bar x700", {red, green, blue}, 12'h000);
            if (c == 799) check("bar x799", {red, green, blue}, 12'h000);
        end
        px(0, 1, 0);
        check("y after line", dut.y, 1);
        // checkerboard over 33 lines
        pattern_sel = 2'd2;
        px(0, 0, 1);
        for (int l = 0; l < 33; l++) begin
            for (int c = 0; c < 800; c++) begin
                px(1, 1, 0);
                if (l == 0 && c == 31)  check("chk 31,0",  {red, green, blue}, 12'h000);
                if (l == 0 && c == 32)  check("chk 32,0",  {red, green, blue}, 12'hFFF);
                if (l == 32 && c == 32) check("chk 32,32", {red, green, blue}, 12'h000);
            end
            px(0, 1, 0);
        end
        // late selection and frame_start without pix_en
        pattern_sel = 2'd2;
        px(0, 0, 1);
        for (int c = 0; c < 40; c++) px(1, 1, 0);
        pattern_sel = 2'd1;
        for (int c = 40; c < 80; c++) begin
            px(1, 1, 0);
            if (c == 64) check("late sel holds", {red, green, blue}, 12'h000);
        end
        pattern_sel = 2'd3;
        frame_start = 1'b1;
        @(posedge pllclk); #1;
        frame_start = 1'b0;
        check("fs no strobe box_x", dut.box_x, bx);
        pattern_sel = 2'd1;
        for (int c = 80; c < 100; c++) px(1, 1, 0);
        px(0, 1, 0);
        px(0, 0, 1);
        for (int c = 0; c < 100; c++) begin
            px(1, 1, 0);
            if (c == 64) check("late sel bars", {red, green, blue}, 12'hFFF);
        end
        // bouncing box
        do_reset(1);
        pattern_sel = 2'd3;
        px(0, 0, 1);
        for (int l = 0; l < 3; l++) begin
            for (int c = 0; c < 800; c++) begin
                px(1, 1, 0);
                if (l == 1 && c == 1)  check("box corner", {red, green, blue}, 12'hF0F);
                if (l == 1 && c == 64) check("box right",  {red, green, blue}, 12'hF0F);
                if (l == 1 && c == 65) check("box past",   {red, green, blue}, 12'h002);
            end
            px(0, 1, 0);
        end
        for (int f = 2; f <= 740; f++) begin
            px(0, 0, 1);
            check("box_x", dut.box_x, bx);
            check("box_y", dut.box_y, by);
            if (f == 736) check("box_x peak", dut.box_x, 736);
            if (f == 737) check("box_x back", dut.box_x, 735);
            if (f == 740) check("box_x end",  dut.box_x, 732);
            if (f == 536) check("box_y peak", dut.box_y, 536);
            if (f == 537) check("box_y back", dut.box_y, 535);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
